// File: rtl/rtx_pkg.sv
// rtx_pkg: shared ray-tracer types (fp24 vectors, ray packet, dispatcher states)
// Contents: fp24_vec3 (x/y/z fp24), ray_pkt_t {pixel_h, pixel_v, origin, dir}, dispatcher_state_e {IDLE, ISSUE, DRAIN}
package rtx_pkg;
  typedef logic [23:0] fp24_t;
  typedef struct packed {
    fp24_t x;
    fp24_t y;
    fp24_t z;
  } fp24_vec3;
  typedef struct packed {
    logic [10:0] pixel_h;
    logic [9:0]  pixel_v;
    fp24_vec3    origin;
    fp24_vec3    dir;
  } ray_pkt_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} dispatcher_state_e;
endpackage

// File: rtl/ray_fifo.sv
// ray_fifo: synchronous FIFO with combinational head
// Ports: clk; rst (sync, active-low); push_i/din_i write; pop_i advances head;
//        dout_o head entry; full_o/empty_o/count_o occupancy status
module ray_fifo
  import rtx_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = ray_pkt_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       din_i,
  output T                       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  always_comb begin
    empty_o = cnt_q == '0;
    full_o  = cnt_q == (AW+1)'(DEPTH);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk)
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: credit-paced ray request, FIFO buffering and round-robin hand-off to tracer cores
// Ports: clk; rst (sync, active-low); frame_start pulse; new_ray request to caster;
//        ray_valid_in + pixel_h_in/pixel_v_in/ray_origin_in/ray_dir_in from caster;
//        core_valid/core_ready one-hot handshake per core; pixel_h/pixel_v/ray_origin/ray_dir FIFO head;
//        busy, frame_done pulse, proto_err sticky.
// Option: DISPATCH_STATS_EN adds stat_rays (rays popped this frame) and stat_stall (head waiting, no core ready).
module ray_dispatcher
  import rtx_pkg::*;
#(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CORES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  output logic                 new_ray,
  input  logic                 ray_valid_in,
  input  logic [10:0]          pixel_h_in,
  input  logic [9:0]           pixel_v_in,
  input  fp24_vec3             ray_origin_in,
  input  fp24_vec3             ray_dir_in,
  output logic [NUM_CORES-1:0] core_valid,
  input  logic [NUM_CORES-1:0] core_ready,
  output logic [10:0]          pixel_h,
  output logic [9:0]           pixel_v,
  output fp24_vec3             ray_origin,
  output fp24_vec3             ray_dir,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 proto_err
`ifdef DISPATCH_STATS_EN
  ,
  output logic [19:0]          stat_rays,
  output logic [31:0]          stat_stall
`endif
);
  localparam logic [19:0] TOTAL = 20'(WIDTH * HEIGHT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  dispatcher_state_e state_q, state_d;
  logic [19:0] issued_q;
  logic [AW:0] inflight_q, fifo_count;
  logic [PW-1:0] rr_q, gidx;
  logic [NUM_CORES-1:0] grant;
  logic proto_err_q, fifo_full, fifo_empty, push, pop, start;
  ray_pkt_t in_pkt, head, hold_q, out_pkt;
  assign in_pkt = {pixel_h_in, pixel_v_in, ray_origin_in, ray_dir_in};
  ray_fifo #(.DEPTH(FIFO_DEPTH), .T(ray_pkt_t)) u_fifo (
    .clk, .rst,
    .push_i(push), .pop_i(pop), .din_i(in_pkt), .dout_o(head),
    .full_o(fifo_full), .empty_o(fifo_empty), .count_o(fifo_count)
  );
  always_ff @(posedge clk) state_q <= !rst ? IDLE : state_d;
  always_comb begin
    state_d = (state_q == IDLE && frame_start) ? ISSUE :
              (state_q == ISSUE && issued_q == TOTAL) ? DRAIN :
              (state_q == DRAIN && inflight_q == '0 && fifo_empty) ? IDLE : state_q;
  end
  // credit: buffered plus in-flight rays never exceed the FIFO capacity
  always_comb begin
    start      = state_q == IDLE && frame_start;
    new_ray    = state_q == ISSUE && issued_q < TOTAL &&
                 (AW+2)'(fifo_count) + (AW+2)'(inflight_q) < (AW+2)'(FIFO_DEPTH);
    busy       = state_q != IDLE;
    frame_done = state_q == DRAIN && inflight_q == '0 && fifo_empty;
  end
  // descending scan so the first ready core at or after rr_q wins the last write
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (core_ready[PW'((int'(rr_q) + k) % NUM_CORES)]) begin
        gidx  = PW'((int'(rr_q) + k) % NUM_CORES);
        grant = NUM_CORES'(1) << gidx;
      end
    core_valid = fifo_empty ? '0 : grant;
    pop        = |core_valid;
    push       = ray_valid_in && inflight_q != '0 && (!fifo_full || pop);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      issued_q    <= '0;
      inflight_q  <= '0;
      rr_q        <= '0;
      proto_err_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (start) issued_q <= '0;
      else if (new_ray) issued_q <= issued_q + 20'd1;
      inflight_q <= inflight_q + (AW+1)'(new_ray) - (AW+1)'(push);
      if (ray_valid_in && !push) proto_err_q <= 1'b1;
      if (pop) begin
        rr_q   <= gidx == PW'(NUM_CORES - 1) ? '0 : gidx + 1'b1;
        hold_q <= head;
      end
    end
  // once drained, the outputs keep showing the last ray handed out
  assign out_pkt = fifo_empty ? hold_q : head;
  assign {pixel_h, pixel_v, ray_origin, ray_dir} = out_pkt;
  assign proto_err = proto_err_q;
`ifdef DISPATCH_STATS_EN
  logic [19:0] stat_rays_q;
  logic [31:0] stat_stall_q;
  always_ff @(posedge clk)
    if (!rst || start) begin
      stat_rays_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (pop && stat_rays_q != '1) stat_rays_q <= stat_rays_q + 20'd1;
      if (!fifo_empty && core_ready == '0 && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 32'd1;
    end
  assign stat_rays  = stat_rays_q;
  assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: directed self-checking bench for ray_dispatcher (4x2 frame, depth 4, 3 cores)
module tb_ray_dispatcher;
  import rtx_pkg::*;
  logic clk = 1'b0, rst = 1'b0, frame_start = 1'b0, ray_valid_in = 1'b0;
  logic [10:0] pixel_h_in = '0;
  logic [9:0] pixel_v_in = '0;
  fp24_vec3 ray_origin_in = '0, ray_dir_in = '0;
  logic [2:0] core_ready = '0;
  logic new_ray, busy, frame_done, proto_err;
  logic [2:0] core_valid;
  logic [10:0] pixel_h;
  logic [9:0] pixel_v;
  fp24_vec3 ray_origin, ray_dir;
`ifdef DISPATCH_STATS_EN
  logic [19:0] stat_rays;
  logic [31:0] stat_stall;
`endif
  ray_dispatcher #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .NUM_CORES(3)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .new_ray(new_ray),
    .ray_valid_in(ray_valid_in), .pixel_h_in(pixel_h_in), .pixel_v_in(pixel_v_in),
    .ray_origin_in(ray_origin_in), .ray_dir_in(ray_dir_in),
    .core_valid(core_valid), .core_ready(core_ready),
    .pixel_h(pixel_h), .pixel_v(pixel_v), .ray_origin(ray_origin), .ray_dir(ray_dir),
    .busy(busy), .frame_done(frame_done), .proto_err(proto_err)
`ifdef DISPATCH_STATS_EN
    , .stat_rays(stat_rays), .stat_stall(stat_stall)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [4:0] pipe = '0;
  bit cast_en = 1'b1;
  int cast_h = 0, cast_v = 0, nreq = 0, nout = 0, nin = 0, ndone = 0, max_out = 0, occ = 0;
  logic [10:0] out_h[$];
  logic [9:0] out_v[$];
  fp24_vec3 out_org[$], out_dir[$];
  logic [2:0] grants[$];
  // Samples the current cycle just before its edge, then plays the 5-cycle caster after the edge.
  task automatic tick();
    #1;
    occ = nin - nout - int'(cast_en && ray_valid_in);
    pipe = {pipe[3:0], new_ray};
    if (new_ray) nreq++;
    if (|core_valid) begin
      nout++;
      out_h.push_back(pixel_h);
      out_v.push_back(pixel_v);
      out_org.push_back(ray_origin);
      out_dir.push_back(ray_dir);
      grants.push_back(core_valid);
    end
    if (frame_done) ndone++;
    if (nreq - nout > max_out) max_out = nreq - nout;
    @(posedge clk);
    #1;
    if (cast_en) begin
      ray_valid_in = pipe[4];
      if (pipe[4]) begin
        pixel_h_in = 11'(cast_h);
        pixel_v_in = 10'(cast_v);
        ray_origin_in = {24'(cast_h), 24'(cast_v), 24'hABCDEF};
        ray_dir_in = {24'(cast_v), 24'(cast_h), 24'h123456};
        nin++;
        cast_h++;
        if (cast_h == 4) begin
          cast_h = 0;
          cast_v++;
        end
      end
    end
  endtask
  task automatic clear_model();
    pipe = '0; cast_h = 0; cast_v = 0; ray_valid_in = 1'b0;
    nreq = 0; nout = 0; nin = 0; ndone = 0; max_out = 0;
    out_h.delete(); out_v.delete(); out_org.delete(); out_dir.delete(); grants.delete();
  endtask
  task automatic do_reset();
    rst = 1'b0; frame_start = 1'b0;
    tick(); tick();
    clear_model();
    rst = 1'b1;
  endtask
  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (ndone == 0 && n < 300) begin tick(); n++; end
    total++;
    if (ndone == 0) begin bad++; $display("FAIL %s_timeout frame_done not seen in %0d cycles", tag, n); end
    tick(); tick();
  endtask
  task automatic test_reset();
    rst = 1'b0; core_ready = 3'b111;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (new_ray !== 1'b0) begin bad++; $display("FAIL reset_new_ray got=%b want=0", new_ray); end
    total++; if (core_valid !== 3'b000) begin bad++; $display("FAIL reset_core_valid got=%b want=000", core_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b want=0", proto_err); end
    total++; if (pixel_h !== 11'd0 || ray_dir !== '0) begin bad++; $display("FAIL reset_head got=%0d/%h want=0/0", pixel_h, ray_dir); end
    clear_model();
    rst = 1'b1;
  endtask
  task automatic test_frame();
    do_reset();
    core_ready = 3'b111;
    start_frame();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_busy got=%b want=1", busy); end
    wait_done("frame");
    total++; if (nreq !== 8) begin bad++; $display("FAIL frame_new_ray got=%0d want=8", nreq); end
    total++; if (nout !== 8) begin bad++; $display("FAIL frame_rays_out got=%0d want=8", nout); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL frame_done_pulses got=%0d want=1", ndone); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_after got=%b want=0", busy); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL frame_proto_err got=%b want=0", proto_err); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_h[i] !== 11'(i % 4) || out_v[i] !== 10'(i / 4)) begin
        bad++; $display("FAIL frame_order[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, out_h[i], out_v[i], i % 4, i / 4);
      end
    end
    total++;
    if (out_org[6] !== {24'd2, 24'd1, 24'hABCDEF} || out_dir[6] !== {24'd1, 24'd2, 24'h123456}) begin
      bad++; $display("FAIL frame_payload got=%h/%h want=%h/%h", out_org[6], out_dir[6],
                      {24'd2, 24'd1, 24'hABCDEF}, {24'd1, 24'd2, 24'h123456});
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    core_ready = 3'b000;
    start_frame();
    repeat (50) tick();
    total++; if (nreq !== 4) begin bad++; $display("FAIL bp_requests got=%0d want=4", nreq); end
    total++; if (nout !== 0) begin bad++; $display("FAIL bp_no_out got=%0d want=0", nout); end
    total++; if (max_out > 4) begin bad++; $display("FAIL bp_outstanding got=%0d want<=4", max_out); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL bp_proto_err got=%b want=0", proto_err); end
    core_ready = 3'b111;
    wait_done("bp");
    total++; if (nout !== 8) begin bad++; $display("FAIL bp_drained got=%0d want=8", nout); end
    total++; if (max_out > 4) begin bad++; $display("FAIL bp_outstanding_end got=%0d want<=4", max_out); end
  endtask
  task automatic test_round_robin();
    logic [2:0] e_all [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] e_skip [4] = '{3'b100, 3'b001, 3'b100, 3'b001};
    do_reset();
    core_ready = 3'b000;
    start_frame();
    repeat (30) tick();
    grants.delete();
    core_ready = 3'b111;
    repeat (4) tick();
    core_ready = 3'b000;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (grants[i] !== e_all[i]) begin bad++; $display("FAIL rr_all[%0d] got=%b want=%b", i, grants[i], e_all[i]); end
    end
    repeat (30) tick();
    grants.delete();
    core_ready = 3'b101;
    repeat (4) tick();
    core_ready = 3'b000;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (grants[i] !== e_skip[i]) begin bad++; $display("FAIL rr_skip[%0d] got=%b want=%b", i, grants[i], e_skip[i]); end
    end
    core_ready = 3'b111;
    wait_done("rr");
    total++; if (nout !== 8 || out_h[7] !== 11'd3 || out_v[7] !== 10'd1) begin
      bad++; $display("FAIL rr_complete got=%0d last=(%0d,%0d) want=8 last=(3,1)", nout, out_h[7], out_v[7]);
    end
  endtask
  task automatic test_proto_err();
    do_reset();
    cast_en = 1'b0;
    core_ready = 3'b111;
    ray_valid_in = 1'b1; pixel_h_in = 11'd9;
    tick();
    ray_valid_in = 1'b0;
    tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_set got=%b want=1", proto_err); end
    total++; if (core_valid !== 3'b000 || pixel_h !== 11'd0) begin
      bad++; $display("FAIL perr_dropped got=%b/%0d want=000/0", core_valid, pixel_h);
    end
    repeat (5) tick();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%b want=1", proto_err); end
    do_reset();
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_reset got=%b want=0", proto_err); end
    cast_en = 1'b1;
  endtask
  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    core_ready = 3'b000;
    start_frame();
    while (nin < 3 && n < 50) begin tick(); n++; end
    tick();
    total++; if (nin < 3) begin bad++; $display("FAIL mid_fill got=%0d want>=3", nin); end
    rst = 1'b0; core_ready = 3'b111;
    clear_model();
    tick();
    total++; if (busy !== 1'b0 || new_ray !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b%b want=00", busy, new_ray); end
    total++; if (core_valid !== 3'b000) begin bad++; $display("FAIL mid_flushed got=%b want=000", core_valid); end
    total++; if (proto_err !== 1'b0 || frame_done !== 1'b0 || pixel_h !== 11'd0) begin
      bad++; $display("FAIL mid_outputs got=%b%b/%0d want=00/0", proto_err, frame_done, pixel_h);
    end
    clear_model();
    rst = 1'b1;
    start_frame();
    wait_done("mid");
    total++; if (nreq !== 8 || nout !== 8) begin bad++; $display("FAIL mid_restart got=%0d/%0d want=8/8", nreq, nout); end
    total++; if (out_h[0] !== 11'd0 || out_v[0] !== 10'd0) begin
      bad++; $display("FAIL mid_first got=(%0d,%0d) want=(0,0)", out_h[0], out_v[0]);
    end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL mid_proto_err got=%b want=0", proto_err); end
  endtask
`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    int n = 0;
    do_reset();
    core_ready = 3'b000;
    start_frame();
    while (occ == 0 && n < 50) begin tick(); n++; end
    repeat (9) tick();
    core_ready = 3'b111;
    wait_done("stats");
    total++; if (stat_rays !== 20'd8) begin bad++; $display("FAIL stats_rays got=%0d want=8", stat_rays); end
    total++; if (stat_stall !== 32'd10) begin bad++; $display("FAIL stats_stall got=%0d want=10", stat_stall); end
  endtask
`endif
  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_round_robin();
    test_proto_err();
    test_mid_reset();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
